// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the three-port AXI3 address-channel arbiter.
// Both the top level and the winner-select block import this package.
package axi_arb_pkg;

    localparam int NUM_PORTS = 3;
    localparam int WEIGHT_W  = 16;
    localparam int IDX_W     = 2;

    typedef enum logic [1:0] {
        ARB_FIXED = 2'd0,
        ARB_RR    = 2'd1,
        ARB_WRR   = 2'd2,
        ARB_RSVD  = 2'd3
    } arb_mode_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Port index increment modulo NUM_PORTS; out-of-range indices fold to port 0.
    function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [IDX_W-1:0] idx);
        return NUM_PORTS'(3'b001 << idx);
    endfunction

    // A programmed weight of zero still allows one grant per turn.
    function automatic logic [WEIGHT_W-1:0] eff_quota(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

endpackage

// File: rtl/axi3_addr_arb_pick.sv
// Combinational winner select for three ports: fixed priority, round robin,
// or weighted round robin where the current owner may continue its burst.
module arb3_pick
    import axi_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] eligible,
    input  logic [IDX_W-1:0]     start,
    input  arb_mode_e            mode,
    input  logic [IDX_W-1:0]     owner,
    input  logic [WEIGHT_W-1:0]  burst_cnt,
    input  logic [WEIGHT_W-1:0]  owner_quota,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 keep
);

    logic [IDX_W-1:0] idx;
    logic             found;
    logic             owner_req;

    always_comb begin
        grant     = '0;
        keep      = 1'b0;
        idx       = start;
        found     = 1'b0;
        owner_req = |(eligible & port_onehot(owner));

        case (mode)
            ARB_RR, ARB_WRR: begin
                // burst_cnt == 0 means no burst is in progress (after reset or a mode change)
                if (mode == ARB_WRR && burst_cnt != '0 && burst_cnt < owner_quota && owner_req) begin
                    keep  = 1'b1;
                    grant = port_onehot(owner);
                end else begin
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        if (!found && |(eligible & port_onehot(idx))) begin
                            grant = port_onehot(idx);
                            found = 1'b1;
                        end
                        idx = next_port(idx);
                    end
                end
            end
            default: begin
                if (eligible[0])      grant = 3'b001;
                else if (eligible[1]) grant = 3'b010;
                else if (eligible[2]) grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/axi3_addr_arb.sv
// Three-port address-channel arbiter with a single registered output slot.
// One instance serves one channel; AW and AR each get their own instance.
module axi3_addr_arb
    import axi_arb_pkg::*;
#(
    parameter int PW = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arb_en,
    input  logic [1:0]              arb_mode,
    input  logic [WEIGHT_W-1:0]     weight_setting0,
    input  logic [WEIGHT_W-1:0]     weight_setting1,
    input  logic [WEIGHT_W-1:0]     weight_setting2,
    input  logic [NUM_PORTS-1:0]    in_valid,
    output logic [NUM_PORTS-1:0]    in_ready,
    input  logic [NUM_PORTS*PW-1:0] in_payload,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PW-1:0]           out_payload,
    output logic [IDX_W-1:0]        out_src
);

    // state      | meaning
    // SLOT_EMPTY | output slot holds nothing, out_valid low
    // SLOT_FULL  | output slot holds a payload, out_valid high

    arb_mode_e            mode;
    arb_mode_e            mode_q;
    slot_state_e          state_q;
    slot_state_e          state_d;
    logic [IDX_W-1:0]     last_grant;
    logic [IDX_W-1:0]     win;
    logic [WEIGHT_W-1:0]  burst_cnt;
    logic [WEIGHT_W-1:0]  burst_d;
    logic [WEIGHT_W-1:0]  owner_quota;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] pick;
    logic [NUM_PORTS-1:0] grant;
    logic                 keep;
    logic                 slot_free;
    logic                 take;

    assign mode      = arb_mode_e'(arb_mode);
    assign eligible  = arb_en ? in_valid : {{(NUM_PORTS-1){1'b0}}, in_valid[0]};
    assign slot_free = (state_q == SLOT_EMPTY) || out_ready;

    always_comb begin
        owner_quota = eff_quota(weight_setting2);
        case (last_grant)
            2'd0:    owner_quota = eff_quota(weight_setting0);
            2'd1:    owner_quota = eff_quota(weight_setting1);
            default: owner_quota = eff_quota(weight_setting2);
        endcase
    end

    arb3_pick u_pick (
        .eligible    (eligible),
        .start       (next_port(last_grant)),
        .mode        (mode),
        .owner       (last_grant),
        .burst_cnt   (burst_cnt),
        .owner_quota (owner_quota),
        .grant       (pick),
        .keep        (keep)
    );

    assign grant    = (slot_free && !rst) ? pick : '0;
    assign take     = |grant;
    assign in_ready = grant;

    always_comb begin
        win = 2'd0;
        case (grant)
            3'b010:  win = 2'd1;
            3'b100:  win = 2'd2;
            default: win = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (take) state_d = SLOT_FULL;
            SLOT_FULL:  if (out_ready) state_d = take ? SLOT_FULL : SLOT_EMPTY;
        endcase
    end

    // A forced reselection in WRR starts a fresh burst even if the same port wins again.
    always_comb begin
        burst_d = burst_cnt;
        if (mode != mode_q) begin
            burst_d = '0;
        end else if (take) begin
            if (keep || (mode != ARB_WRR && win == last_grant))
                burst_d = (burst_cnt == '1) ? burst_cnt : burst_cnt + WEIGHT_W'(1);
            else
                burst_d = WEIGHT_W'(1);
        end
    end

    assign out_valid = (state_q == SLOT_FULL);

    // mode_q tracks the live mode through reset so that leaving reset is not seen as a mode change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SLOT_EMPTY;
            out_payload <= '0;
            out_src     <= '0;
            last_grant  <= 2'd2;
            burst_cnt   <= '0;
            mode_q      <= mode;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode;
            burst_cnt <= burst_d;
            if (take) begin
                out_payload <= in_payload[win*PW +: PW];
                out_src     <= win;
                last_grant  <= win;
            end
        end
    end

endmodule

// File: tb/tb_axi3_addr_arb.sv
// Directed testbench for axi3_addr_arb: reset, fixed/RR/WRR ordering, back-pressure,
// arbitration disable, mode-change burst clear and reset mid-transfer.
module tb_axi3_addr_arb;

    localparam int PW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          arb_en;
    logic [1:0]    arb_mode;
    logic [15:0]   weight_setting0, weight_setting1, weight_setting2;
    logic [2:0]    in_valid;
    logic [2:0]    in_ready;
    logic [3*PW-1:0] in_payload;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_payload;
    logic [1:0]    out_src;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    axi3_addr_arb #(.PW(PW)) dut (
        .clk             (clk),
        .rst             (rst),
        .arb_en          (arb_en),
        .arb_mode        (arb_mode),
        .weight_setting0 (weight_setting0),
        .weight_setting1 (weight_setting1),
        .weight_setting2 (weight_setting2),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_payload      (in_payload),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_payload     (out_payload),
        .out_src         (out_src)
    );

    // Port i carries {i+1, tag} so the owner of the slot is visible in the payload.
    task automatic set_payloads(input int tag);
        for (int i = 0; i < 3; i++)
            in_payload[i*PW +: PW] = {8'(i + 1), 56'(tag)};
    endtask

    // Leaves the bench at a falling edge with rst just released.
    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    // Per-cycle invariants: one-hot in_ready and output stability under back-pressure.
    logic          prev_stall = 1'b0;
    logic [PW-1:0] prev_pay;
    logic [1:0]    prev_src;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            n_total++;
            if (!$onehot0(in_ready)) $display("FAIL onehot_ready got=%b required=at most one bit", in_ready);
            else n_pass++;
            if (prev_stall) begin
                n_total++;
                if (out_valid !== 1'b1 || out_payload !== prev_pay || out_src !== prev_src)
                    $display("FAIL stall_stable got v=%b src=%0d pay=%h required v=1 src=%0d pay=%h",
                             out_valid, out_src, out_payload, prev_src, prev_pay);
                else n_pass++;
            end
            prev_stall = out_valid && !out_ready;
            prev_pay   = out_payload;
            prev_src   = out_src;
        end
    end

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b required=0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 3'b000) $display("FAIL reset_ready got=%b required=000", in_ready); else n_pass++;
        n_total++; if (out_src !== 2'd0) $display("FAIL reset_src got=%0d required=0", out_src); else n_pass++;
        n_total++; if (out_payload !== '0) $display("FAIL reset_payload got=%h required=0", out_payload); else n_pass++;
    endtask

    task automatic test_fixed(input logic [1:0] mode);
        arb_mode = mode; in_valid = 3'b111; out_ready = 1'b1; set_payloads(1);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            #1;
            n_total++; if (in_ready !== 3'b001) $display("FAIL fixed_ready m=%0d k=%0d got=%b required=001", mode, k, in_ready); else n_pass++;
            if (k > 0) begin
                n_total++; if (out_src !== 2'd0) $display("FAIL fixed_src m=%0d k=%0d got=%0d required=0", mode, k, out_src); else n_pass++;
            end
            @(negedge clk);
        end
        in_valid = 3'b110; #1;
        n_total++; if (in_ready !== 3'b010) $display("FAIL fixed_p1_ready m=%0d got=%b required=010", mode, in_ready); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (out_src !== 2'd1) $display("FAIL fixed_p1_src m=%0d got=%0d required=1", mode, out_src); else n_pass++;
        n_total++; if (in_ready !== 3'b010) $display("FAIL fixed_p1_hold m=%0d got=%b required=010", mode, in_ready); else n_pass++;
        @(negedge clk); in_valid = 3'b100; #1;
        n_total++; if (in_ready !== 3'b100) $display("FAIL fixed_p2_ready m=%0d got=%b required=100", mode, in_ready); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (out_src !== 2'd2) $display("FAIL fixed_p2_src m=%0d got=%0d required=2", mode, out_src); else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_src[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
        arb_mode = 2'd1; in_valid = 3'b111; out_ready = 1'b1; set_payloads(7);
        do_reset();
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k < 9) begin
                n_total++;
                if (in_ready !== 3'(1 << exp_src[k])) $display("FAIL rr_ready k=%0d got=%b required=%b", k, in_ready, 3'(1 << exp_src[k]));
                else n_pass++;
            end
            if (k > 0) begin
                n_total++;
                if (out_valid !== 1'b1 || out_src !== 2'(exp_src[k-1]))
                    $display("FAIL rr_src k=%0d got v=%b src=%0d required v=1 src=%0d", k, out_valid, out_src, exp_src[k-1]);
                else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_weighted(input logic [15:0] w1);
        int exp_src[12] = '{0, 0, 0, 1, 2, 2, 0, 0, 0, 1, 2, 2};
        arb_mode = 2'd2; in_valid = 3'b111; out_ready = 1'b1; set_payloads(9);
        weight_setting0 = 16'd3; weight_setting1 = w1; weight_setting2 = 16'd2;
        do_reset();
        for (int k = 0; k < 13; k++) begin
            #1;
            if (k < 12) begin
                n_total++;
                if (in_ready !== 3'(1 << exp_src[k])) $display("FAIL wrr_ready w1=%0d k=%0d got=%b required=%b", w1, k, in_ready, 3'(1 << exp_src[k]));
                else n_pass++;
            end
            if (k > 0) begin
                n_total++;
                if (out_src !== 2'(exp_src[k-1])) $display("FAIL wrr_src w1=%0d k=%0d got=%0d required=%0d", w1, k, out_src, exp_src[k-1]);
                else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mode_change();
        arb_mode = 2'd2; in_valid = 3'b111; out_ready = 1'b1;
        weight_setting0 = 16'd3; weight_setting1 = 16'd1; weight_setting2 = 16'd2;
        do_reset();
        @(negedge clk);
        @(negedge clk) arb_mode = 2'd1; #1;
        n_total++; if (in_ready !== 3'b010) $display("FAIL mchg_rr got=%b required=010", in_ready); else n_pass++;
        @(negedge clk) arb_mode = 2'd2; #1;
        n_total++; if (in_ready !== 3'b100) $display("FAIL mchg_back got=%b required=100", in_ready); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (in_ready !== 3'b001) $display("FAIL mchg_fresh got=%b required=001", in_ready); else n_pass++;
    endtask

    task automatic test_back_pressure();
        arb_mode = 2'd1; in_valid = 3'b111; out_ready = 1'b1; set_payloads(100);
        do_reset();
        #1;
        n_total++; if (in_ready !== 3'b001) $display("FAIL bp_first got=%b required=001", in_ready); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk) out_ready = 1'b0; set_payloads(200 + c); #1;
            n_total++; if (in_ready !== 3'b000) $display("FAIL bp_ready c=%0d got=%b required=000", c, in_ready); else n_pass++;
            n_total++;
            if (out_valid !== 1'b1 || out_src !== 2'd0 || out_payload !== {8'd1, 56'd100})
                $display("FAIL bp_hold c=%0d got v=%b src=%0d pay=%h required v=1 src=0 pay=%h", c, out_valid, out_src, out_payload, {8'd1, 56'd100});
            else n_pass++;
        end
        @(negedge clk) out_ready = 1'b1; set_payloads(300); #1;
        n_total++; if (in_ready !== 3'b010) $display("FAIL bp_release got=%b required=010", in_ready); else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (out_valid !== 1'b1 || out_src !== 2'd1 || out_payload !== {8'd2, 56'd300})
            $display("FAIL bp_next got v=%b src=%0d pay=%h required v=1 src=1 pay=%h", out_valid, out_src, out_payload, {8'd2, 56'd300});
        else n_pass++;
        n_total++; if (in_ready !== 3'b100) $display("FAIL bp_b2b got=%b required=100", in_ready); else n_pass++;
    endtask

    task automatic test_arb_disabled();
        arb_en = 1'b0; arb_mode = 2'd1; in_valid = 3'b111; out_ready = 1'b1; set_payloads(5);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            #1;
            n_total++; if (in_ready !== 3'b001) $display("FAIL dis_ready k=%0d got=%b required=001", k, in_ready); else n_pass++;
            if (k > 0) begin
                n_total++; if (out_src !== 2'd0) $display("FAIL dis_src k=%0d got=%0d required=0", k, out_src); else n_pass++;
            end
            @(negedge clk);
        end
        in_valid = 3'b110; #1;
        n_total++; if (in_ready !== 3'b000) $display("FAIL dis_masked got=%b required=000", in_ready); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL dis_drain got=%b required=0", out_valid); else n_pass++;
        arb_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        arb_mode = 2'd1; in_valid = 3'b111; out_ready = 1'b1; set_payloads(11);
        do_reset();
        @(negedge clk);
        @(negedge clk) out_ready = 1'b0; rst = 1'b1;
        @(negedge clk); #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got=%b required=0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 3'b000) $display("FAIL rmid_ready got=%b required=000", in_ready); else n_pass++;
        rst = 1'b0; out_ready = 1'b1; #1;
        n_total++; if (in_ready !== 3'b001) $display("FAIL rmid_first got=%b required=001", in_ready); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (out_valid !== 1'b1 || out_src !== 2'd0) $display("FAIL rmid_src got v=%b src=%0d required v=1 src=0", out_valid, out_src); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; arb_en = 1'b1; arb_mode = 2'd0; out_ready = 1'b1; in_valid = 3'b111;
        weight_setting0 = 16'd1; weight_setting1 = 16'd1; weight_setting2 = 16'd1;
        set_payloads(0);
        test_reset();
        test_fixed(2'd0);
        test_fixed(2'd3);
        test_round_robin();
        test_weighted(16'd1);
        test_weighted(16'd0);
        test_mode_change();
        test_back_pressure();
        test_arb_disabled();
        test_reset_mid();
        @(negedge clk); #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi3_addr_arb.md
AXI3_ADDR_ARB -- requirements
Module: axi3_addr_arb

Interface
REQ-001 Parameter PW, default 64: payload width per port (address plus attributes).
REQ-002 clk  in  1  sole clock, all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 arb_en  in  1  arbitration enable; 0 means only port 0 is served.
REQ-005 arb_mode  in  2  0 fixed priority, 1 round robin, 2 weighted round robin, 3 reserved.
REQ-006 weight_setting0/1/2  in  16 each  consecutive-grant quota for ports 0/1/2 in mode 2.
REQ-007 in_valid  in  3  per-port request valid; bit i belongs to port i.
REQ-008 in_ready  out  3  per-port accept.
REQ-009 in_payload  in  3*PW  port i occupies bits [i*PW +: PW].
REQ-010 out_valid  out  1  downstream valid.
REQ-011 out_ready  in  1  downstream ready.
REQ-012 out_payload  out  PW  registered payload of the granted port.
REQ-013 out_src  out  2  index of the port that owns out_payload.

Function
REQ-014 Output stage: one register slot (payload, src, valid); "slot free" = !out_valid || out_ready.
REQ-015 Arbitration runs only when slot free; the winner's in_ready is asserted in that same cycle, combinationally, and at most one in_ready bit is high per cycle.
REQ-016 On winner handshake, the slot loads in_payload[winner] and winner; out_valid = 1 next cycle. Latency is 1 cycle; back-to-back throughput is 1 per cycle.
REQ-017 out_valid, out_payload and out_src stay stable while out_valid && !out_ready (AXI rule); no loss or reordering.
REQ-018 When slot free and no eligible request: out_valid deasserts next cycle and in_ready = 0.
REQ-019 arb_en = 0: eligible set = {port 0} only; in_ready[2:1] = 0.
REQ-020 Mode 0: priority 0 > 1 > 2.
REQ-021 Mode 1: search starts at last_grant+1 (mod 3) and wraps 2 -> 0; last_grant updates on every grant.
REQ-022 Mode 2: the current owner keeps winning while it requests and burst_cnt < quota. quota = weight_settingN, with weight 0 treated as 1. When the quota is reached, or the owner drops valid, select as in mode 1. A sole requester is always granted and burst_cnt restarts at 1.
REQ-023 burst_cnt: 16 bits, saturating. Set to 1 on a grant to a new owner; +1 on a grant to the same owner.
REQ-024 Mode 3 behaves as mode 0.
REQ-025 arb_mode, arb_en and weights are sampled every arbitration cycle. A change never disturbs a payload already in the slot. A mode change clears burst_cnt to 0 on the next cycle.
REQ-026 FSM per REQ-014: EMPTY (out_valid=0) -> FULL on grant. FULL -> FULL on out_ready with a new grant. FULL -> EMPTY on out_ready with no grant. FULL holds otherwise.

Reset
REQ-027 During rst: out_valid=0, in_ready=0, out_src=0, out_payload=0, last_grant=2 (so the first round-robin search starts at port 0), burst_cnt=0, FSM=EMPTY.
REQ-028 Reset mid-transfer discards the slot contents without emitting them; the first grant after reset follows REQ-027 state.

Structure
REQ-029 Shared package axi_arb_pkg holds the arb_mode enum (ARB_FIXED, ARB_RR, ARB_WRR, ARB_RSVD), NUM_PORTS=3 and the weight width 16.
REQ-030 One sub-module, arb3_pick: combinational winner select from eligible mask, start index, mode and owner/quota inputs; output is a one-hot grant.
REQ-031 Two instances serve the AW and AR channels independently; they share configuration inputs but no state.

Verification
REQ-032 Mode 0, all three valid continuously, out_ready=1 -> every grant is port 0. After port 0 drops, port 1 is granted; port 2 only once ports 0 and 1 are idle.
REQ-033 Mode 1, all valid, out_ready=1, 9 cycles after reset -> out_src sequence 0,1,2,0,1,2,0,1,2.
REQ-034 Mode 2, weights 3/1/2, all valid -> out_src sequence 0,0,0,1,2,2,0,0,0,1,2,2. Weight 0 on port 1 with weights 3/0/2 -> sequence identical to weight 1.
REQ-035 out_ready held 0 for 5 cycles with a payload in the slot -> out_payload and out_src are constant and in_ready = 0 throughout. After release, the next grant appears with no bubble.
REQ-036 arb_en=0, all valid -> only port 0 is handshaked and in_ready[2:1] = 0 every cycle. Assertion checks: at most one in_ready bit high per cycle, and out stability under back-pressure.
REQ-037 Assert rst while FULL in mode 1 -> next cycle out_valid=0. The first grant after release goes to port 0 when all ports request.
